mem_access_seq: RTL and testbench

- Sequences every MEM-stage load/store onto the single-ported data bus (DM/bridge) using a req/ack handshake.
- Generates byte enables and store-lane replication.
- Performs load lane selection plus sign/zero extension, and raises AdEL/AdES/bus-error exceptions.
- Sits between the MEM pipeline register and the system bridge; holds the pipeline via stall while an access is outstanding.

---
 rtl/mem_access_seq_pkg.sv | 48 ++++
 rtl/mem_access_seq_fmt.sv | 63 ++++++
 rtl/mem_access_seq.sv | 166 ++++++++++++++++
 tb/tb_mem_access_seq.sv | 257 +++++++++++++++++++++++++
 4 files changed

// File: rtl/mem_access_seq_pkg.sv
// Shared definitions for the MEM-stage bus access sequencer.
//   - Memory access length codes presented on req_len.
//   - Exception codes reported on exc_code.
//   - Sequencer FSM state encoding.
//   - Helpers that decode the access size and check address alignment.
package mem_access_seq_pkg;

  // Access length codes driven by the MEM stage.
  localparam logic [7:0] MEM_LEN_W = 8'd0;
  localparam logic [7:0] MEM_LEN_H = 8'd1;
  localparam logic [7:0] MEM_LEN_B = 8'd2;

  // Exception codes.
  localparam logic [4:0] EXC_ADEL = 5'd4;  // misaligned load
  localparam logic [4:0] EXC_ADES = 5'd5;  // misaligned store
  localparam logic [4:0] EXC_DBE  = 5'd7;  // bus error (ack timeout)

  typedef enum logic [1:0] {
    MS_IDLE = 2'd0,
    MS_BUS  = 2'd1,
    MS_RESP = 2'd2,
    MS_EXC  = 2'd3
  } ms_state_e;

  typedef enum logic [1:0] {
    SZ_W = 2'd0,
    SZ_H = 2'd1,
    SZ_B = 2'd2
  } mem_size_e;

  // Any unrecognised length code is handled as a full word access.
  function automatic mem_size_e decode_len(input logic [7:0] len);
    case (len)
      MEM_LEN_H: return SZ_H;
      MEM_LEN_B: return SZ_B;
      default:   return SZ_W;
    endcase
  endfunction

  function automatic logic addr_aligned(input mem_size_e sz, input logic [1:0] lo);
    case (sz)
      SZ_W:    return lo == 2'b00;
      SZ_H:    return !lo[0];
      default: return 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/mem_access_seq_fmt.sv
// mem_lane_fmt: combinational lane formatting for the access sequencer.
//   Store side (driven from the incoming request):
//     st_we, st_len, st_addr_lo, st_wdata -> st_byteen, st_wdata_rep
//     Byte enables and replicated data are zero for loads.
//   Load side (driven from the captured access and the bus read word):
//     ld_len, ld_addr_lo, ld_unsigned, ld_rdata -> ld_data
//     Selects the addressed lane and sign/zero-extends it to 32 bits.
module mem_lane_fmt
  import mem_access_seq_pkg::*;
(
  input  logic        st_we,
  input  logic [7:0]  st_len,
  input  logic [1:0]  st_addr_lo,
  input  logic [31:0] st_wdata,
  output logic [3:0]  st_byteen,
  output logic [31:0] st_wdata_rep,
  input  logic [7:0]  ld_len,
  input  logic [1:0]  ld_addr_lo,
  input  logic        ld_unsigned,
  input  logic [31:0] ld_rdata,
  output logic [31:0] ld_data
);

  mem_size_e   st_size;
  mem_size_e   ld_size;
  logic [7:0]  ld_byte;
  logic [15:0] ld_half;

  always_comb begin
    // NOTE: every output gets a default before the case so no path leaves it
    // unassigned; otherwise synthesis infers a latch.
    st_size      = decode_len(st_len);
    st_byteen    = 4'b1111;
    st_wdata_rep = st_wdata;
    case (st_size)
      SZ_H: begin
        st_byteen    = st_addr_lo[1] ? 4'b1100 : 4'b0011;
        st_wdata_rep = {2{st_wdata[15:0]}};
      end
      SZ_B: begin
        st_byteen    = 4'b0001 << st_addr_lo;
        st_wdata_rep = {4{st_wdata[7:0]}};
      end
      default: ;
    endcase
    if (!st_we) begin
      st_byteen    = 4'b0000;
      st_wdata_rep = 32'h0;
    end
  end

  always_comb begin
    ld_size = decode_len(ld_len);
    ld_byte = 8'(ld_rdata >> {ld_addr_lo, 3'b000});
    ld_half = ld_addr_lo[1] ? ld_rdata[31:16] : ld_rdata[15:0];
    case (ld_size)
      SZ_H:    ld_data = {{16{ld_half[15] & ~ld_unsigned}}, ld_half};
      SZ_B:    ld_data = {{24{ld_byte[7] & ~ld_unsigned}}, ld_byte};
      default: ld_data = ld_rdata;
    endcase
  end

endmodule

// File: rtl/mem_access_seq.sv
// mem_access_seq: sequences MEM-stage loads/stores onto the single-ported
// data bus with a req/ack handshake.
//   Request side : req_valid, req_we, req_len, req_unsigned, req_addr,
//                  req_wdata, flush (in); stall (out)
//   Result side  : rsp_valid/rsp_rdata (load data or store completion),
//                  exc_valid/exc_code (AdEL, AdES, DBE)
//   Bus side     : bus_req, bus_we, bus_addr, bus_byteen, bus_wdata (out);
//                  bus_ack, bus_rdata (in)
//   reset is asynchronous and active-low.
module mem_access_seq
  import mem_access_seq_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 16  // legal range 2..255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  input  logic        req_we,
  input  logic [7:0]  req_len,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  input  logic        flush,
  output logic        stall,
  output logic        rsp_valid,
  output logic [31:0] rsp_rdata,
  output logic        exc_valid,
  output logic [4:0]  exc_code,
  output logic        bus_req,
  output logic        bus_we,
  output logic [31:0] bus_addr,
  output logic [3:0]  bus_byteen,
  output logic [31:0] bus_wdata,
  input  logic        bus_ack,
  input  logic [31:0] bus_rdata
);

  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT_CYCLES - 1);

  // Everything the bus cycle and the load formatting need, captured at accept.
  typedef struct packed {
    logic [31:0] addr;
    logic [7:0]  len;
    logic        we;
    logic        uns;
    logic [3:0]  byteen;
    logic [31:0] wdata;
  } acc_t;

  ms_state_e   state_q, state_d;
  acc_t        acc_q, acc_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] rdata_q, rdata_d;
  logic [4:0]  code_q, code_d;
  logic        suppress_q, suppress_d;

  logic [3:0]  fmt_byteen;
  logic [31:0] fmt_wdata;
  logic [31:0] fmt_ldata;

  mem_lane_fmt u_fmt (
    .st_we        (req_we),
    .st_len       (req_len),
    .st_addr_lo   (req_addr[1:0]),
    .st_wdata     (req_wdata),
    .st_byteen    (fmt_byteen),
    .st_wdata_rep (fmt_wdata),
    .ld_len       (acc_q.len),
    .ld_addr_lo   (acc_q.addr[1:0]),
    .ld_unsigned  (acc_q.uns),
    .ld_rdata     (bus_rdata),
    .ld_data      (fmt_ldata)
  );

  // State and capture registers.
  // NOTE: the capture registers are reset too, so every bus/result output is
  // a defined 0 straight out of reset rather than whatever the flops power up to.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= MS_IDLE;
      acc_q      <= '0;
      cnt_q      <= '0;
      rdata_q    <= '0;
      code_q     <= '0;
      suppress_q <= 1'b0;
    end else begin
      // NOTE: non-blocking so all registers update together from pre-edge values.
      state_q    <= state_d;
      acc_q      <= acc_d;
      cnt_q      <= cnt_d;
      rdata_q    <= rdata_d;
      code_q     <= code_d;
      suppress_q <= suppress_d;
    end
  end

  // Next-state and capture logic.
  always_comb begin
    state_d    = state_q;
    acc_d      = acc_q;
    cnt_d      = cnt_q;
    rdata_d    = rdata_q;
    code_d     = code_q;
    suppress_d = suppress_q;
    case (state_q)
      MS_IDLE: begin
        cnt_d      = '0;
        suppress_d = 1'b0;
        if (req_valid && !flush) begin
          acc_d = '{addr: req_addr, len: req_len, we: req_we, uns: req_unsigned,
                    byteen: fmt_byteen, wdata: fmt_wdata};
          if (addr_aligned(decode_len(req_len), req_addr[1:0])) begin
            state_d = MS_BUS;
          end else begin
            code_d  = req_we ? EXC_ADES : EXC_ADEL;
            state_d = MS_EXC;
          end
        end
      end
      MS_BUS: begin
        // A flush cannot abandon the handshake; it only hides the result.
        if (flush) suppress_d = 1'b1;
        // Ack is tested first so an ack in the limit cycle still completes.
        if (bus_ack) begin
          rdata_d = acc_q.we ? 32'h0 : fmt_ldata;
          cnt_d   = '0;
          state_d = MS_RESP;
        end else if (cnt_q == CNT_LAST) begin
          code_d  = EXC_DBE;
          cnt_d   = '0;
          state_d = MS_EXC;
        end else begin
          cnt_d = cnt_q + 8'd1;
        end
      end
      default: state_d = MS_IDLE;  // RESP / EXC last exactly one cycle
    endcase
  end

  // Outputs.
  always_comb begin
    logic in_bus;
    logic presenting;
    in_bus     = state_q == MS_BUS;
    presenting = !suppress_q && !flush;

    bus_req    = in_bus;
    bus_we     = in_bus & acc_q.we;
    bus_addr   = in_bus ? {acc_q.addr[31:2], 2'b00} : 32'h0;
    bus_byteen = in_bus ? acc_q.byteen : 4'b0000;
    bus_wdata  = in_bus ? acc_q.wdata : 32'h0;

    rsp_valid  = (state_q == MS_RESP) && presenting;
    rsp_rdata  = rsp_valid ? rdata_q : 32'h0;
    exc_valid  = (state_q == MS_EXC) && presenting;
    exc_code   = exc_valid ? code_q : 5'd0;

    // The MEM stage is released in the cycle its result is presented. After a
    // flush the old access is orphaned: stall no longer holds for it, but any
    // new request must wait (including through a suppressed RESP/EXC cycle)
    // until the FSM is back in IDLE.
    stall = !flush &&
            ((req_valid && !(rsp_valid || exc_valid)) || (in_bus && !suppress_q));
  end

endmodule

// File: tb/tb_mem_access_seq.sv
// Self-checking bench for mem_access_seq: directed accesses with a simple
// programmable-latency bus responder and a response scoreboard.
module tb_mem_access_seq;
  import mem_access_seq_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_we, req_unsigned, flush;
  logic [7:0]  req_len;
  logic [31:0] req_addr, req_wdata;
  logic        stall, rsp_valid, exc_valid;
  logic [31:0] rsp_rdata;
  logic [4:0]  exc_code;
  logic        bus_req, bus_we, bus_ack;
  logic [31:0] bus_addr, bus_wdata, bus_rdata;
  logic [3:0]  bus_byteen;

  mem_access_seq #(.TIMEOUT_CYCLES(16)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_we(req_we), .req_len(req_len),
    .req_unsigned(req_unsigned), .req_addr(req_addr), .req_wdata(req_wdata),
    .flush(flush), .stall(stall),
    .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .exc_valid(exc_valid), .exc_code(exc_code),
    .bus_req(bus_req), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_byteen(bus_byteen), .bus_wdata(bus_wdata),
    .bus_ack(bus_ack), .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Scoreboard of expected result pulses.
  typedef struct {
    logic        is_exc;
    logic [4:0]  code;
    logic [31:0] rdata;
    string       tag;
  } sb_item_t;
  sb_item_t sb_q[$];
  sb_item_t mon_item;

  always @(negedge clk) begin
    if (reset && (rsp_valid || exc_valid)) begin
      check("pulse_exclusive", 32'(rsp_valid & exc_valid), 32'd0);
      if (sb_q.size() == 0) begin
        check("spurious_pulse", 32'(rsp_valid | exc_valid), 32'd0);
      end else begin
        mon_item = sb_q.pop_front();
        check({mon_item.tag, ":is_exc"}, 32'(exc_valid), 32'(mon_item.is_exc));
        if (mon_item.is_exc) check({mon_item.tag, ":exc_code"}, 32'(exc_code), 32'(mon_item.code));
        else                 check({mon_item.tag, ":rsp_rdata"}, rsp_rdata, mon_item.rdata);
      end
    end
  end

  // Bus responder: acks on the ack_after-th BUS cycle (0 = first), never if < 0.
  int          ack_after = -1;
  int          bus_cnt   = 0;
  int          req_hi    = 0;
  logic [31:0] bus_word  = 32'h0;

  task automatic step();
    @(posedge clk);
    #1;
    if (bus_req) begin
      req_hi++;
      if (ack_after >= 0 && bus_cnt == ack_after) begin
        bus_ack   = 1'b1;
        bus_rdata = bus_word;
      end else begin
        bus_ack   = 1'b0;
        bus_rdata = 32'h0BAD_0BAD;
      end
      bus_cnt++;
    end else begin
      bus_ack   = 1'b0;
      bus_rdata = 32'h0BAD_0BAD;
      bus_cnt   = 0;
    end
  endtask

  task automatic drive_req(input logic we, input logic [7:0] len, input logic uns,
                           input logic [31:0] addr, input logic [31:0] wdata);
    req_valid    = 1'b1;
    req_we       = we;
    req_len      = len;
    req_unsigned = uns;
    req_addr     = addr;
    req_wdata    = wdata;
  endtask

  // One complete access, entered and left just after a rising edge in IDLE.
  task automatic access(input string tag, input logic we, input logic [7:0] len,
                        input logic uns, input logic [31:0] addr, input logic [31:0] wdata,
                        input logic [31:0] rd_word, input int ack_at,
                        input logic exp_exc, input logic [4:0] exp_code,
                        input logic [31:0] exp_rdata, input logic [31:0] exp_baddr,
                        input logic [3:0] exp_ben, input logic [31:0] exp_bwdata,
                        input int exp_lat, input int exp_req_cycles);
    int  lat;
    bit  done;
    bus_word  = rd_word;
    ack_after = ack_at;
    req_hi    = 0;
    drive_req(we, len, uns, addr, wdata);
    sb_q.push_back('{exp_exc, exp_code, exp_rdata, tag});
    @(negedge clk);
    check({tag, ":stall_accept"}, 32'(stall), 32'd1);
    lat  = 0;
    done = 1'b0;
    while (!done && lat < 64) begin
      step();
      lat++;
      @(negedge clk);
      if (bus_req) begin
        check({tag, ":bus_addr"}, bus_addr, exp_baddr);
        check({tag, ":bus_byteen"}, 32'(bus_byteen), 32'(exp_ben));
        check({tag, ":bus_we"}, 32'(bus_we), 32'(we));
        if (we) check({tag, ":bus_wdata"}, bus_wdata, exp_bwdata);
        check({tag, ":stall_bus"}, 32'(stall), 32'd1);
      end
      if (rsp_valid || exc_valid) done = 1'b1;
    end
    check({tag, ":latency"}, 32'(lat), 32'(exp_lat));
    check({tag, ":stall_result"}, 32'(stall), 32'd0);
    check({tag, ":req_cycles"}, 32'(req_hi), 32'(exp_req_cycles));
    req_valid = 1'b0;
    step();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0;
    req_valid = 1'b0; req_we = 1'b0; req_len = MEM_LEN_W; req_unsigned = 1'b0;
    req_addr = 32'h0; req_wdata = 32'h0; flush = 1'b0;
    bus_ack = 1'b0; bus_rdata = 32'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst:stall", 32'(stall), 32'd0);
    check("rst:bus_req", 32'(bus_req), 32'd0);
    check("rst:bus_addr", bus_addr, 32'd0);
    check("rst:bus_byteen", 32'(bus_byteen), 32'd0);
    check("rst:bus_wdata", bus_wdata, 32'd0);
    check("rst:rsp_valid", 32'(rsp_valid), 32'd0);
    check("rst:exc_valid", 32'(exc_valid), 32'd0);
    check("rst:rsp_rdata", rsp_rdata, 32'd0);
    check("rst:exc_code", 32'(exc_code), 32'd0);
    reset = 1'b1;
    step();

    //      tag        we    len        uns   addr           wdata          rd_word        ack  exc   code      rdata          baddr          ben      bwdata         lat req
    access("lb_1003",  1'b0, MEM_LEN_B, 1'b0, 32'h0000_1003, 32'h0,         32'h80FF_1234, 0,  1'b0, 5'd0,     32'hFFFF_FF80, 32'h0000_1000, 4'b0000, 32'h0,         2,  1);
    access("sh_2002",  1'b1, MEM_LEN_H, 1'b0, 32'h0000_2002, 32'h0000_ABCD, 32'h0,         2,  1'b0, 5'd0,     32'h0,         32'h0000_2000, 4'b1100, 32'hABCD_ABCD, 4,  3);
    access("sb_0001",  1'b1, MEM_LEN_B, 1'b0, 32'h0000_0001, 32'h1234_5678, 32'h0,         0,  1'b0, 5'd0,     32'h0,         32'h0000_0000, 4'b0010, 32'h7878_7878, 2,  1);
    access("lh_0002",  1'b0, MEM_LEN_H, 1'b0, 32'h0000_0002, 32'h0,         32'h8001_0000, 1,  1'b0, 5'd0,     32'hFFFF_8001, 32'h0000_0000, 4'b0000, 32'h0,         3,  2);
    access("lw_unk",   1'b0, 8'hFF,     1'b0, 32'h0000_0008, 32'h0,         32'hCAFE_F00D, 0,  1'b0, 5'd0,     32'hCAFE_F00D, 32'h0000_0008, 4'b0000, 32'h0,         2,  1);
    access("lw_3001",  1'b0, MEM_LEN_W, 1'b0, 32'h0000_3001, 32'h0,         32'h0,         0,  1'b1, EXC_ADEL, 32'h0,         32'h0,         4'b0000, 32'h0,         1,  0);
    access("sw_3002",  1'b1, MEM_LEN_W, 1'b0, 32'h0000_3002, 32'h5555_5555, 32'h0,         0,  1'b1, EXC_ADES, 32'h0,         32'h0,         4'b0000, 32'h0,         1,  0);
    access("lhu_tmo",  1'b0, MEM_LEN_H, 1'b1, 32'h0000_4000, 32'h0,         32'h0,         -1, 1'b1, EXC_DBE,  32'h0,         32'h0000_4000, 4'b0000, 32'h0,         17, 16);
    access("lh_limit", 1'b0, MEM_LEN_H, 1'b0, 32'h0000_4002, 32'h0,         32'h7FFF_0000, 15, 1'b0, 5'd0,     32'h0000_7FFF, 32'h0000_4000, 4'b0000, 32'h0,         17, 16);

    // Flush in the second BUS cycle of an LW; ack arrives on the fourth.
    bus_word  = 32'hDEAD_BEEF;
    ack_after = 3;
    req_hi    = 0;
    drive_req(1'b0, MEM_LEN_W, 1'b0, 32'h0000_5000, 32'h0);
    @(negedge clk);
    check("flush:stall_accept", 32'(stall), 32'd1);
    step();                                   // BUS 1
    @(negedge clk);
    check("flush:bus1_req", 32'(bus_req), 32'd1);
    step();                                   // BUS 2
    flush = 1'b1;
    req_valid = 1'b0;
    @(negedge clk);
    check("flush:stall_on_flush", 32'(stall), 32'd0);
    check("flush:bus2_req", 32'(bus_req), 32'd1);
    step();                                   // BUS 3, new request waiting
    flush = 1'b0;
    drive_req(1'b0, MEM_LEN_B, 1'b0, 32'h0000_5104, 32'h0);
    @(negedge clk);
    check("flush:bus3_req", 32'(bus_req), 32'd1);
    check("flush:bus3_addr", bus_addr, 32'h0000_5000);
    check("flush:stall_new_req", 32'(stall), 32'd1);
    step();                                   // BUS 4, ack
    @(negedge clk);
    check("flush:bus4_req", 32'(bus_req), 32'd1);
    check("flush:bus4_addr", bus_addr, 32'h0000_5000);
    step();                                   // RESP, suppressed
    @(negedge clk);
    check("flush:rsp_suppressed", 32'(rsp_valid), 32'd0);
    check("flush:exc_suppressed", 32'(exc_valid), 32'd0);
    check("flush:resp_bus_req", 32'(bus_req), 32'd0);
    check("flush:stall_resp", 32'(stall), 32'd1);
    check("flush:old_req_cycles", 32'(req_hi), 32'd4);
    bus_word  = 32'h1122_337F;
    ack_after = 0;
    sb_q.push_back('{1'b0, 5'd0, 32'h0000_007F, "flush_next"});
    step();                                   // IDLE, new request accepted
    @(negedge clk);
    check("flush:idle_bus_req", 32'(bus_req), 32'd0);
    check("flush:idle_stall", 32'(stall), 32'd1);
    step();                                   // BUS for new request
    @(negedge clk);
    check("flush:new_bus_req", 32'(bus_req), 32'd1);
    check("flush:new_bus_addr", bus_addr, 32'h0000_5104);
    check("flush:new_byteen", 32'(bus_byteen), 32'd0);
    step();                                   // RESP for new request
    @(negedge clk);
    check("flush:new_rsp_valid", 32'(rsp_valid), 32'd1);
    check("flush:new_stall", 32'(stall), 32'd0);
    req_valid = 1'b0;
    step();

    // Reset asserted mid-access: outputs must drop without a clock edge.
    bus_word  = 32'h0;
    ack_after = -1;
    drive_req(1'b0, MEM_LEN_W, 1'b0, 32'h0000_7000, 32'h0);
    step();                                   // BUS
    @(negedge clk);
    check("rst_mid:bus_req_before", 32'(bus_req), 32'd1);
    #2;
    reset = 1'b0;
    req_valid = 1'b0;
    #1;
    check("rst_mid:bus_req_async", 32'(bus_req), 32'd0);
    check("rst_mid:stall_async", 32'(stall), 32'd0);
    check("rst_mid:bus_addr_async", bus_addr, 32'd0);
    step();
    @(negedge clk);
    reset = 1'b1;
    step();
    access("lbu_6001", 1'b0, MEM_LEN_B, 1'b1, 32'h0000_6001, 32'h0, 32'h0000_9900, 0, 1'b0, 5'd0, 32'h0000_0099, 32'h0000_6000, 4'b0000, 32'h0, 2, 1);

    repeat (3) step();
    check("scoreboard_drained", 32'(sb_q.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
